hazard_scoreboard: RTL and testbench

Parametrised hazard-detection and forwarding controller for the in-order MIPS pipeline. It supersedes the fixed two-source, one-cycle load-use checker and the combinational forwarding selector. It keeps a shift-register scoreboard of in-flight destination registers for every stage from EX to WB. From that it generates stall, bubble, flush and registered forwarding selects, and it counts stall and flush cycles for performance reporting. It sits in the ID stage, beside the control unit, and drives the PC, IF/ID and ID/EX enables and the EX operand multiplexers.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_scoreboard_src_match.sv | 31 +++
 rtl/hazard_scoreboard.sv | 125 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: entry layout, forwarding encoding, clog2 helper.
package hazard_pkg;

    localparam int unsigned SB_AW_MAX = 8;
    localparam int unsigned SB_AGE_W  = 4;
    localparam int unsigned FWD_RF    = 0;

    typedef struct packed {
        logic                 v;
        logic [SB_AW_MAX-1:0] dst;
        logic                 we;
        logic                 load;
        logic [SB_AGE_W-1:0]  age;
    } sb_entry_t;

    function automatic int unsigned sb_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// One source operand against every scoreboard entry; the youngest matching producer wins.
module hs_src_match
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 3
) (
    input  logic [REG_AW-1:0]   src,
    input  logic                used,
    input  sb_entry_t           ent [1:DEPTH],
    output logic                hit,
    output logic [SB_AGE_W-1:0] k,
    output logic                is_load
);

    // Scan oldest to youngest so a younger match overwrites an older one.
    always_comb begin
        hit     = 1'b0;
        k       = '0;
        is_load = 1'b0;
        for (int unsigned j = DEPTH; j > 0; j--) begin
            if (used && (src != '0) && ent[j].v && ent[j].we &&
                (ent[j].dst == SB_AW_MAX'(src))) begin
                hit     = 1'b1;
                k       = ent[j].age;
                is_load = ent[j].load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard controller: in-flight destination scoreboard, load-use stall,
// branch flush, registered forwarding selects and saturating stall/flush counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned BR_STAGE = 2,
    parameter int unsigned FWD_W    = sb_clog2(DEPTH),
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]  id_src,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [REG_AW-1:0]          id_dst,
    input  logic                       id_we,
    input  logic                       id_load,
    input  logic                       br_taken,
    output logic                       pc_en,
    output logic                       ifid_en,
    output logic                       idex_bubble,
    output logic                       flush_ifid,
    output logic [NUM_SRC*FWD_W-1:0]   fwd_sel,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    sb_entry_t                ent_q [1:DEPTH];
    sb_entry_t                ent_d [1:DEPTH];
    logic [NUM_SRC-1:0]       src_hit;
    logic [NUM_SRC-1:0]       src_load;
    logic [SB_AGE_W-1:0]      src_k [NUM_SRC];
    logic                     stall;
    logic                     insert;
    logic [NUM_SRC*FWD_W-1:0] fwd_sel_d, fwd_sel_q;
    logic [CNT_W-1:0]         stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0]         flush_cnt_d, flush_cnt_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hs_src_match #(
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH)
        ) u_match (
            .src     (id_src[i*REG_AW +: REG_AW]),
            .used    (id_src_used[i]),
            .ent     (ent_q),
            .hit     (src_hit[i]),
            .k       (src_k[i]),
            .is_load (src_load[i])
        );
    end

    always_comb begin
        stall = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_hit[i] && src_load[i] && (src_k[i] <= SB_AGE_W'(LOAD_LAT))) begin
                stall = 1'b1;
            end
        end
        stall       = stall && id_valid;
        insert      = id_valid && !stall && !br_taken;
        pc_en       = !rst && (br_taken || !stall);
        ifid_en     = !rst && (br_taken || !stall);
        idex_bubble = rst || stall || br_taken;
        flush_ifid  = !rst && br_taken;
    end

    // Entry age equals its stage index, so it doubles as the forwarding distance.
    always_comb begin
        ent_d = '{default: '0};
        if (insert) begin
            ent_d[1].v    = 1'b1;
            ent_d[1].dst  = SB_AW_MAX'(id_dst);
            ent_d[1].we   = id_we;
            ent_d[1].load = id_load;
            ent_d[1].age  = SB_AGE_W'(1);
        end
        for (int unsigned j = 1; j < DEPTH; j++) begin
            ent_d[j+1]     = ent_q[j];
            ent_d[j+1].age = ent_q[j].age + SB_AGE_W'(1);
            if (br_taken && (j < BR_STAGE)) begin
                ent_d[j+1].v = 1'b0;
            end
        end

        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            fwd_sel_d[i*FWD_W +: FWD_W] = FWD_W'(FWD_RF);
            if (insert && src_hit[i] && (src_k[i] < SB_AGE_W'(DEPTH))) begin
                fwd_sel_d[i*FWD_W +: FWD_W] = FWD_W'(src_k[i]);
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && !br_taken && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (br_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q       <= '{default: '0};
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ent_q       <= ent_d;
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_sel   = fwd_sel_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of hazard_scoreboard at default parameters and at DEPTH=4/LOAD_LAT=2/NUM_SRC=3.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Default-parameter instance
    logic        a_rst, a_id_valid, a_id_we, a_id_load, a_br_taken;
    logic [9:0]  a_id_src;
    logic [1:0]  a_id_src_used;
    logic [4:0]  a_id_dst;
    logic        a_pc_en, a_ifid_en, a_idex_bubble, a_flush_ifid;
    logic [3:0]  a_fwd_sel;
    logic [15:0] a_stall_cnt, a_flush_cnt;

    hazard_scoreboard u_dut_a (
        .clk         (clk),
        .rst         (a_rst),
        .id_valid    (a_id_valid),
        .id_src      (a_id_src),
        .id_src_used (a_id_src_used),
        .id_dst      (a_id_dst),
        .id_we       (a_id_we),
        .id_load     (a_id_load),
        .br_taken    (a_br_taken),
        .pc_en       (a_pc_en),
        .ifid_en     (a_ifid_en),
        .idex_bubble (a_idex_bubble),
        .flush_ifid  (a_flush_ifid),
        .fwd_sel     (a_fwd_sel),
        .stall_cnt   (a_stall_cnt),
        .flush_cnt   (a_flush_cnt)
    );

    // Deeper instance with narrow counters so saturation is reachable quickly
    logic        b_rst, b_id_valid, b_id_we, b_id_load, b_br_taken;
    logic [14:0] b_id_src;
    logic [2:0]  b_id_src_used;
    logic [4:0]  b_id_dst;
    logic        b_pc_en, b_ifid_en, b_idex_bubble, b_flush_ifid;
    logic [5:0]  b_fwd_sel;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    hazard_scoreboard #(
        .REG_AW   (5),
        .NUM_SRC  (3),
        .DEPTH    (4),
        .LOAD_LAT (2),
        .BR_STAGE (2),
        .CNT_W    (4)
    ) u_dut_b (
        .clk         (clk),
        .rst         (b_rst),
        .id_valid    (b_id_valid),
        .id_src      (b_id_src),
        .id_src_used (b_id_src_used),
        .id_dst      (b_id_dst),
        .id_we       (b_id_we),
        .id_load     (b_id_load),
        .br_taken    (b_br_taken),
        .pc_en       (b_pc_en),
        .ifid_en     (b_ifid_en),
        .idex_bubble (b_idex_bubble),
        .flush_ifid  (b_flush_ifid),
        .fwd_sel     (b_fwd_sel),
        .stall_cnt   (b_stall_cnt),
        .flush_cnt   (b_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drv_a(input logic v, input logic [4:0] s1, input logic [4:0] s0,
                         input logic [1:0] used, input logic [4:0] dst,
                         input logic we, input logic ld, input logic br);
        a_id_valid    = v;
        a_id_src      = {s1, s0};
        a_id_src_used = used;
        a_id_dst      = dst;
        a_id_we       = we;
        a_id_load     = ld;
        a_br_taken    = br;
    endtask

    task automatic drv_b(input logic v, input logic [4:0] s2, input logic [4:0] s1,
                         input logic [4:0] s0, input logic [2:0] used, input logic [4:0] dst,
                         input logic we, input logic ld, input logic br);
        b_id_valid    = v;
        b_id_src      = {s2, s1, s0};
        b_id_src_used = used;
        b_id_dst      = dst;
        b_id_we       = we;
        b_id_load     = ld;
        b_br_taken    = br;
    endtask

    task automatic idle_a(input int n);
        drv_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (n) cyc();
    endtask

    task automatic idle_b(input int n);
        drv_b(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (n) cyc();
    endtask

    initial begin
        a_rst = 1'b1;
        b_rst = 1'b1;
        drv_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        drv_b(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);

        // Reset state
        cyc();
        settle();
        chk("rst_pc_en",     a_pc_en, 0);
        chk("rst_ifid_en",   a_ifid_en, 0);
        chk("rst_bubble",    a_idex_bubble, 1);
        chk("rst_flush",     a_flush_ifid, 0);
        chk("rst_fwd",       a_fwd_sel, 0);
        chk("rst_stall_cnt", a_stall_cnt, 0);
        chk("rst_flush_cnt", a_flush_cnt, 0);
        chk("rst_b_bubble",  b_idex_bubble, 1);
        cyc();
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Back-to-back ALU dependency: add r3 ; sub r5,r3,r4
        drv_a(1'b1, 5'd2, 5'd1, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t1_add_pc_en",  a_pc_en, 1);
        chk("t1_add_bubble", a_idex_bubble, 0);
        cyc();
        drv_a(1'b1, 5'd4, 5'd3, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t1_sub_no_stall", a_pc_en, 1);
        chk("t1_add_fwd",      a_fwd_sel, 0);
        cyc();
        drv_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t1_sub_fwd", a_fwd_sel, 4'b0001);
        idle_a(3);

        // Load-use: lw r2 ; add r6,r2,r2
        drv_a(1'b1, 5'd0, 5'd1, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0);
        cyc();
        drv_a(1'b1, 5'd2, 5'd2, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t2_stall_pc_en",   a_pc_en, 0);
        chk("t2_stall_ifid_en", a_ifid_en, 0);
        chk("t2_stall_bubble",  a_idex_bubble, 1);
        chk("t2_stall_flush",   a_flush_ifid, 0);
        cyc();
        settle();
        chk("t2_release_pc_en",  a_pc_en, 1);
        chk("t2_release_bubble", a_idex_bubble, 0);
        chk("t2_stall_cnt",      a_stall_cnt, 1);
        chk("t2_bubble_fwd",     a_fwd_sel, 0);
        cyc();
        drv_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t2_add_fwd",   a_fwd_sel, 4'b1010);
        chk("t2_stall_cnt_hold", a_stall_cnt, 1);
        idle_a(3);

        // Youngest-first priority and r0
        drv_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0);
        cyc();
        cyc();
        drv_a(1'b1, 5'd0, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t3_no_stall", a_pc_en, 1);
        cyc();
        drv_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b0);
        settle();
        chk("t3_youngest_fwd", a_fwd_sel, 4'b0001);
        cyc();
        drv_a(1'b1, 5'd0, 5'd0, 2'b11, 5'd9, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t3_r0_no_stall", a_pc_en, 1);
        cyc();
        drv_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t3_r0_fwd", a_fwd_sel, 0);
        idle_a(3);

        // Taken branch on a load-use stall cycle
        drv_a(1'b1, 5'd0, 5'd1, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0);
        cyc();
        drv_a(1'b1, 5'd2, 5'd2, 2'b11, 5'd6, 1'b1, 1'b0, 1'b1);
        settle();
        chk("t4_br_pc_en",   a_pc_en, 1);
        chk("t4_br_ifid_en", a_ifid_en, 1);
        chk("t4_br_flush",   a_flush_ifid, 1);
        chk("t4_br_bubble",  a_idex_bubble, 1);
        cyc();
        drv_a(1'b1, 5'd0, 5'd2, 2'b01, 5'd10, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t4_flush_cnt", a_flush_cnt, 1);
        chk("t4_stall_cnt", a_stall_cnt, 1);
        chk("t4_flush_off", a_flush_ifid, 0);
        cyc();
        drv_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t4_invalidated_fwd", a_fwd_sel, 0);
        idle_a(3);

        // id_valid low never stalls
        drv_a(1'b1, 5'd0, 5'd1, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0);
        cyc();
        drv_a(1'b0, 5'd2, 5'd2, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t5_invalid_pc_en",  a_pc_en, 1);
        chk("t5_invalid_bubble", a_idex_bubble, 0);
        idle_a(4);
        chk("t5_stall_cnt", a_stall_cnt, 1);

        // Reset asserted mid-stall
        drv_a(1'b1, 5'd0, 5'd1, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0);
        cyc();
        drv_a(1'b1, 5'd2, 5'd2, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        a_rst = 1'b1;
        settle();
        chk("t6_rst_pc_en",  a_pc_en, 0);
        chk("t6_rst_bubble", a_idex_bubble, 1);
        chk("t6_rst_flush",  a_flush_ifid, 0);
        cyc();
        a_rst = 1'b0;
        settle();
        chk("t6_post_pc_en",     a_pc_en, 1);
        chk("t6_post_stall_cnt", a_stall_cnt, 0);
        chk("t6_post_flush_cnt", a_flush_cnt, 0);
        cyc();
        drv_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t6_cleared_fwd", a_fwd_sel, 0);

        // Deep instance: load at e[1] stalls two cycles, then forwards from stage 3
        drv_b(1'b1, 5'd0, 5'd0, 5'd1, 3'b001, 5'd9, 1'b1, 1'b1, 1'b0);
        cyc();
        drv_b(1'b1, 5'd0, 5'd0, 5'd9, 3'b001, 5'd12, 1'b1, 1'b0, 1'b0);
        settle();
        chk("b_stall1", b_pc_en, 0);
        cyc();
        settle();
        chk("b_stall2", b_pc_en, 0);
        cyc();
        settle();
        chk("b_release",   b_pc_en, 1);
        chk("b_stall_cnt", b_stall_cnt, 2);
        cyc();
        drv_b(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("b_load_fwd3", b_fwd_sel, 6'b000011);
        idle_b(4);

        // Third source matches e[3]; then a match only at e[DEPTH] reads the register file
        drv_b(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd11, 1'b1, 1'b0, 1'b0);
        cyc();
        drv_b(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        drv_b(1'b1, 5'd11, 5'd0, 5'd0, 3'b100, 5'd13, 1'b1, 1'b0, 1'b0);
        cyc();
        drv_b(1'b1, 5'd0, 5'd11, 5'd0, 3'b010, 5'd14, 1'b1, 1'b0, 1'b0);
        settle();
        chk("b_src2_e3_fwd", b_fwd_sel, 6'b110000);
        cyc();
        drv_b(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("b_e4_rf_fwd", b_fwd_sel, 0);
        idle_b(4);

        // Repeated self-dependent loads saturate the 4-bit stall counter
        drv_b(1'b1, 5'd0, 5'd0, 5'd9, 3'b001, 5'd9, 1'b1, 1'b1, 1'b0);
        repeat (30) cyc();
        settle();
        chk("b_stall_cnt_sat", b_stall_cnt, 4'hF);
        b_rst = 1'b1;
        cyc();
        b_rst = 1'b0;
        settle();
        chk("b_rst_stall_cnt", b_stall_cnt, 0);
        chk("b_rst_flush_cnt", b_flush_cnt, 0);
        chk("b_rst_pc_en",     b_pc_en, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
